// File: rtl/rgen_apb_register_array.sv
// APB register slave: NUM_REGS registers, each RW, RO or W1C, with wait states and IRQ OR-reduce.
// Optional build macro: RGEN_APB_PROT_CHECK_EN rejects unprivileged accesses (i_pprot[0]=0).
module rgen_apb_register_array #(
  parameter int unsigned                    DATA_WIDTH         = 32,
  parameter int unsigned                    HOST_ADDRESS_WIDTH = 16,
  parameter int unsigned                    NUM_REGS           = 8,
  parameter logic [NUM_REGS-1:0]            RO_MASK            = '0,
  parameter logic [NUM_REGS-1:0]            W1C_MASK           = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] INITIAL_VALUE      = '0,
  parameter int unsigned                    WAIT_CYCLES        = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [HOST_ADDRESS_WIDTH-1:0]  i_paddr,
  input  logic [2:0]                     i_pprot,
  input  logic                           i_psel,
  input  logic                           i_penable,
  input  logic                           i_pwrite,
  input  logic [DATA_WIDTH-1:0]          i_pwdata,
  input  logic [DATA_WIDTH/8-1:0]        i_pstrb,
  output logic                           o_pready,
  output logic [DATA_WIDTH-1:0]          o_prdata,
  output logic                           o_pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_reg_value,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] i_reg_input,
  output logic                           o_irq
);

  localparam int unsigned BYTES    = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(BYTES);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic complete;

  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_q, reg_d;

  logic [HOST_ADDRESS_WIDTH-1:0] idx;
  logic [NUM_REGS-1:0]           sel;
  logic [DATA_WIDTH-1:0]         bit_mask;
  logic [DATA_WIDTH-1:0]         rdata;
  logic                          prot_err;
  logic                          err;
  logic                          commit;

  // Byte-lane bits below ADDR_LSB fall out of the shift and are ignored.
  assign idx = i_paddr >> ADDR_LSB;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i] = (idx == HOST_ADDRESS_WIDTH'(i));
    end
  end

  always_comb begin
    bit_mask = '0;
    for (int b = 0; b < BYTES; b++) begin
      bit_mask[b*8 +: 8] = {8{i_pstrb[b]}};
    end
  end

`ifdef RGEN_APB_PROT_CHECK_EN
  assign prot_err = ~i_pprot[0];
`else
  assign prot_err = 1'b0;
`endif

  logic unused_pprot;
  assign unused_pprot = ^i_pprot;

  assign err    = ~|sel | (i_pwrite & |(sel & RO_MASK)) | prot_err;
  assign commit = complete & i_pwrite & ~err;

  // RO registers have no storage; reads see the live hardware input.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel[i]) begin
        rdata = RO_MASK[i] ? i_reg_input[i*DATA_WIDTH +: DATA_WIDTH] : reg_q[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_psel && !i_penable) begin
          if (WAIT_CYCLES == 0) begin
            state_d  = StDone;
            complete = 1'b1;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!i_psel) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d  = StDone;
          complete = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pready_d  = complete;
    pslverr_d = complete & err;
    prdata_d  = (complete && !err && !i_pwrite) ? rdata : '0;
  end

  // W1C: the clear is applied before the OR so a simultaneous hardware set wins.
  always_comb begin
    reg_d = reg_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (RO_MASK[i]) begin
        reg_d[i] = reg_q[i];
      end else if (W1C_MASK[i]) begin
        if (commit && sel[i]) begin
          reg_d[i] = reg_q[i] & ~(i_pwdata & bit_mask);
        end
        reg_d[i] = reg_d[i] | i_reg_input[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (commit && sel[i]) begin
        reg_d[i] = (reg_q[i] & ~bit_mask) | (i_pwdata & bit_mask);
      end
    end
  end

  always_comb begin
    o_reg_value = '0;
    o_irq       = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      o_reg_value[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : reg_q[i];
      if (W1C_MASK[i] && !RO_MASK[i]) begin
        o_irq = o_irq | (|reg_q[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      reg_q     <= INITIAL_VALUE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      reg_q     <= reg_d;
    end
  end

  assign o_pready  = pready_q;
  assign o_pslverr = pslverr_q;
  assign o_prdata  = prdata_q;

endmodule

// File: tb/tb_rgen_apb_register_array.sv
// Bench for rgen_apb_register_array: a zero-wait instance and a 3-wait-state instance with
// RW/W1C/RO registers, driven by a vector table plus hand sequences for W1C, abort and pprot.
module tb_rgen_apb_register_array;

  localparam logic [255:0] INIT_MAIN = {224'h0, 32'hA5A5_0000};

  logic         clk;
  logic         rst_n;
  logic [15:0]  paddr;
  logic [2:0]   pprot;
  logic         psel0, psel1, penable, pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [255:0] reg_input;

  logic         pready0, pslverr0, irq0;
  logic [31:0]  prdata0;
  logic [255:0] reg_value0;
  logic         pready1, pslverr1, irq1;
  logic [31:0]  prdata1;
  logic [255:0] reg_value1;

  int checks = 0;
  int errors = 0;

  rgen_apb_register_array #(
    .DATA_WIDTH(32), .HOST_ADDRESS_WIDTH(16), .NUM_REGS(8),
    .RO_MASK(8'h00), .W1C_MASK(8'h00), .INITIAL_VALUE(INIT_MAIN), .WAIT_CYCLES(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_paddr(paddr), .i_pprot(pprot), .i_psel(psel0),
    .i_penable(penable), .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_pready(pready0), .o_prdata(prdata0), .o_pslverr(pslverr0),
    .o_reg_value(reg_value0), .i_reg_input(reg_input), .o_irq(irq0)
  );

  // reg2 W1C, reg3 RO, reg4 both (RO wins).
  rgen_apb_register_array #(
    .DATA_WIDTH(32), .HOST_ADDRESS_WIDTH(16), .NUM_REGS(8),
    .RO_MASK(8'b0001_1000), .W1C_MASK(8'b0001_0100), .INITIAL_VALUE(INIT_MAIN),
    .WAIT_CYCLES(3)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_paddr(paddr), .i_pprot(pprot), .i_psel(psel1),
    .i_penable(penable), .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_pready(pready1), .o_prdata(prdata1), .o_pslverr(pslverr1),
    .o_reg_value(reg_value1), .i_reg_input(reg_input), .o_irq(irq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apb(input bit tgt, input logic [15:0] addr, input bit wr,
                     input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                     output logic [31:0] rdata, output logic err, output int lat,
                     output logic [255:0] rv);
    @(negedge clk);
    psel0 = !tgt; psel1 = tgt; penable = 1'b0;
    paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb; pprot = prot;
    @(negedge clk);
    penable = 1'b1;
    lat = 1;
    while (!(tgt ? pready1 : pready0) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = tgt ? prdata1 : prdata0;
    err   = tgt ? pslverr1 : pslverr0;
    rv    = tgt ? reg_value1 : reg_value0;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  typedef struct {
    string       name;
    bit          tgt;
    logic [15:0] addr;
    bit          wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          chk_idx;
    logic [31:0] exp_reg;
  } vec_t;

  vec_t vecs[$];

  logic [31:0]  rd;
  logic         er;
  int           lt;
  logic [255:0] rv;
  int           seen;

  initial begin
    vecs.push_back('{"d0_rd0",       0, 16'h00, 0, 32'h0,         4'hF, 32'hA5A5_0000, 0, 1, -1, 32'h0});
    vecs.push_back('{"d0_rd0_lowbit",0, 16'h03, 0, 32'h0,         4'hF, 32'hA5A5_0000, 0, 1, -1, 32'h0});
    vecs.push_back('{"rd0",          1, 16'h00, 0, 32'h0,         4'hF, 32'hA5A5_0000, 0, 4, -1, 32'h0});
    vecs.push_back('{"wr1_strb5",    1, 16'h04, 1, 32'h1234_5678, 4'h5, 32'h0,         0, 4,  1, 32'h0034_0078});
    vecs.push_back('{"rd1",          1, 16'h04, 0, 32'h0,         4'hF, 32'h0034_0078, 0, 4,  1, 32'h0034_0078});
    vecs.push_back('{"wr1_strb0",    1, 16'h04, 1, 32'hFFFF_FFFF, 4'h0, 32'h0,         0, 4,  1, 32'h0034_0078});
    vecs.push_back('{"wr1_strbA",    1, 16'h04, 1, 32'hAABB_CCDD, 4'hA, 32'h0,         0, 4,  1, 32'hAA34_CC78});
    vecs.push_back('{"rd3_ro",       1, 16'h0C, 0, 32'h0,         4'hF, 32'hDEAD_BEEF, 0, 4,  3, 32'h0});
    vecs.push_back('{"wr3_ro",       1, 16'h0C, 1, 32'h0,         4'hF, 32'h0,         1, 4,  3, 32'h0});
    vecs.push_back('{"rd3_again",    1, 16'h0C, 0, 32'h0,         4'hF, 32'hDEAD_BEEF, 0, 4, -1, 32'h0});
    vecs.push_back('{"rd4_ro_w1c",   1, 16'h10, 0, 32'h0,         4'hF, 32'h4444_4444, 0, 4, -1, 32'h0});
    vecs.push_back('{"wr4_ro_w1c",   1, 16'h10, 1, 32'hFFFF_FFFF, 4'hF, 32'h0,         1, 4,  4, 32'h0});
    vecs.push_back('{"rd_unmapped",  1, 16'h20, 0, 32'h0,         4'hF, 32'h0,         1, 4, -1, 32'h0});
    vecs.push_back('{"wr_unmapped",  1, 16'h24, 1, 32'hFFFF_FFFF, 4'hF, 32'h0,         1, 4,  1, 32'hAA34_CC78});
    vecs.push_back('{"wr7",          1, 16'h1C, 1, 32'hCAFE_0001, 4'hF, 32'h0,         0, 4,  7, 32'hCAFE_0001});
    vecs.push_back('{"rd7",          1, 16'h1C, 0, 32'h0,         4'hF, 32'hCAFE_0001, 0, 4, -1, 32'h0});

    rst_n = 1'b0; psel0 = 0; psel1 = 0; penable = 0; pwrite = 0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b001;
    reg_input = '0;
    reg_input[1*32 +: 32] = 32'hFFFF_FFFF;  // RW slice: must be ignored
    reg_input[3*32 +: 32] = 32'hDEAD_BEEF;
    reg_input[4*32 +: 32] = 32'h4444_4444;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_pready",   {63'h0, pready1},       64'h0);
    chk("rst_prdata",   {32'h0, prdata1},       64'h0);
    chk("rst_pslverr",  {63'h0, pslverr1},      64'h0);
    chk("rst_reg0",     {32'h0, reg_value1[31:0]}, {32'h0, 32'hA5A5_0000});
    chk("rst_reg3_ro0", {32'h0, reg_value1[3*32 +: 32]}, 64'h0);
    chk("rst_irq",      {63'h0, irq1},          64'h0);
    chk("rst_irq_d0",   {63'h0, irq0},          64'h0);

    foreach (vecs[k]) begin
      apb(vecs[k].tgt, vecs[k].addr, vecs[k].wr, vecs[k].wdata, vecs[k].strb, 3'b001,
          rd, er, lt, rv);
      chk({vecs[k].name, "_lat"},   lt,  vecs[k].exp_lat);
      chk({vecs[k].name, "_err"},   {63'h0, er},  {63'h0, vecs[k].exp_err});
      chk({vecs[k].name, "_rdata"}, {32'h0, rd},  {32'h0, vecs[k].exp_rdata});
      if (vecs[k].chk_idx >= 0) begin
        chk({vecs[k].name, "_reg"}, {32'h0, rv[vecs[k].chk_idx*32 +: 32]},
            {32'h0, vecs[k].exp_reg});
      end
    end

    // W1C: hardware set pulse, then software clears.
    @(negedge clk); reg_input[2*32 +: 32] = 32'h11;
    @(negedge clk); reg_input[2*32 +: 32] = 32'h0;
    chk("w1c_set",     {32'h0, reg_value1[2*32 +: 32]}, 64'h11);
    chk("w1c_irq_set", {63'h0, irq1}, 64'h1);
    apb(1, 16'h08, 0, 32'h0, 4'hF, 3'b001, rd, er, lt, rv);
    chk("w1c_rd", {32'h0, rd}, 64'h11);
    apb(1, 16'h08, 1, 32'h1, 4'hF, 3'b001, rd, er, lt, rv);
    chk("w1c_clr_b0",  {32'h0, rv[2*32 +: 32]}, 64'h10);
    chk("w1c_irq_hold", {63'h0, irq1}, 64'h1);
    apb(1, 16'h08, 1, 32'h10, 4'hE, 3'b001, rd, er, lt, rv);
    chk("w1c_nostrb", {32'h0, rv[2*32 +: 32]}, 64'h10);
    reg_input[2*32 +: 32] = 32'h10;
    apb(1, 16'h08, 1, 32'h10, 4'hF, 3'b001, rd, er, lt, rv);
    reg_input[2*32 +: 32] = 32'h0;
    chk("w1c_set_wins", {32'h0, rv[2*32 +: 32]}, 64'h10);
    apb(1, 16'h08, 1, 32'h10, 4'hF, 3'b001, rd, er, lt, rv);
    @(negedge clk);
    chk("w1c_clr_b4", {32'h0, reg_value1[2*32 +: 32]}, 64'h0);
    chk("w1c_irq_clr", {63'h0, irq1}, 64'h0);

    // Protection: unprivileged write.
    apb(1, 16'h04, 1, 32'h0BAD_F00D, 4'hF, 3'b000, rd, er, lt, rv);
    chk("prot0_lat", lt, 4);
`ifdef RGEN_APB_PROT_CHECK_EN
    chk("prot0_err", {63'h0, er}, 64'h1);
    chk("prot0_reg", {32'h0, rv[1*32 +: 32]}, {32'h0, 32'hAA34_CC78});
`else
    chk("prot0_err", {63'h0, er}, 64'h0);
    chk("prot0_reg", {32'h0, rv[1*32 +: 32]}, {32'h0, 32'h0BAD_F00D});
`endif
    apb(1, 16'h04, 1, 32'h600D_CAFE, 4'hF, 3'b001, rd, er, lt, rv);
    chk("prot1_err", {63'h0, er}, 64'h0);
    chk("prot1_reg", {32'h0, rv[1*32 +: 32]}, {32'h0, 32'h600D_CAFE});

    // Abort: drop psel during the wait phase of a write.
    @(negedge clk);
    psel1 = 1'b1; penable = 1'b0; paddr = 16'h04; pwrite = 1'b1;
    pwdata = 32'hFFFF_FFFF; pstrb = 4'hF; pprot = 3'b001;
    @(negedge clk);
    penable = 1'b1;
    seen = pready1 ? 1 : 0;
    psel1 = 1'b0; penable = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (pready1) seen++;
    end
    chk("abort_no_pready", seen, 0);
    chk("abort_no_commit", {32'h0, reg_value1[1*32 +: 32]}, {32'h0, 32'h600D_CAFE});

    // Transfer after an abort still works.
    apb(1, 16'h04, 0, 32'h0, 4'hF, 3'b001, rd, er, lt, rv);
    chk("post_abort_lat", lt, 4);
    chk("post_abort_rd", {32'h0, rd}, {32'h0, 32'h600D_CAFE});
    @(negedge clk);
    chk("idle_prdata_zero", {32'h0, prdata1}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgen_apb_register_array.md
Name: rgen_apb_register_array

Overview:
- Parametrised APB register slave: NUM_REGS registers of DATA_WIDTH, each register selectable as RW, RO or W1C (hardware-set, write-1-to-clear).
- Adds programmable wait states, byte strobes, error response and interrupt aggregation in one block.
- Replaces the per-register address-decoder/bit-field instance tree in generated register blocks.
- Sits between the APB fabric and block-local logic.

Parameters:
- DATA_WIDTH, 32, bus/register width; 8, 16, 32 or 64.
- HOST_ADDRESS_WIDTH, 16, width of i_paddr.
- NUM_REGS, 8, number of registers, 1..256.
- RO_MASK, '0, NUM_REGS bits; bit i=1 makes register i read-only.
- W1C_MASK, '0, NUM_REGS bits; bit i=1 makes register i W1C. RO_MASK wins if both are set.
- INITIAL_VALUE, '0, NUM_REGS*DATA_WIDTH bits; reset value, register i at slice [i*DATA_WIDTH +: DATA_WIDTH].
- WAIT_CYCLES, 0, extra access-phase cycles before o_pready, 0..15.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i_paddr  input  HOST_ADDRESS_WIDTH  byte address
- i_pprot  input  3  APB protection
- i_psel  input  1  select
- i_penable  input  1  access phase
- i_pwrite  input  1  1=write
- i_pwdata  input  DATA_WIDTH  write data
- i_pstrb  input  DATA_WIDTH/8  byte strobes
- o_pready  output  1  transfer complete
- o_prdata  output  DATA_WIDTH  read data
- o_pslverr  output  1  error response
- o_reg_value  output  NUM_REGS*DATA_WIDTH  current register contents (RW/W1C); RO slices driven 0
- i_reg_input  input  NUM_REGS*DATA_WIDTH  RO: readback value; W1C: per-bit set pulses; RW: unused
- o_irq  output  1  OR of all bits of all W1C registers

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE; wait counter 0.
  - o_pready=0, o_prdata=0, o_pslverr=0.
  - Registers load INITIAL_VALUE; o_irq follows the reset register contents.
- Decode:
  - BYTES=DATA_WIDTH/8; index = i_paddr >> log2(BYTES).
  - Unmapped if index >= NUM_REGS; low log2(BYTES) address bits are ignored.
- FSM states IDLE, WAIT, DONE; o_pready, o_prdata, o_pslverr are registered:
  - IDLE: at an edge sampling i_psel=1, i_penable=0:
    - WAIT_CYCLES==0: go to DONE.
    - Otherwise: load counter with WAIT_CYCLES and go to WAIT.
  - WAIT: counter decrements each edge. At an edge with counter==1 go to DONE.
  - DONE: o_pready=1 for exactly one cycle, then IDLE.
  - Completion edge = the edge entering DONE:
    - Writes commit on this edge.
    - o_prdata and o_pslverr load on this edge.
    - Written value is visible on o_reg_value during the o_pready cycle.
  - Latency: o_pready is high in access-phase cycle WAIT_CYCLES+1.
- Abort: i_psel=0 sampled in WAIT returns the FSM to IDLE. No commit, no o_pready.
- Error (o_pslverr=1, no register change, o_prdata=0):
  - Unmapped address.
  - Write to an RO register.
- Writes:
  - RW: byte b is replaced by i_pwdata byte b where i_pstrb[b]=1.
  - W1C: bit cleared where the written bit is 1 and its byte strobe is 1.
  - All-zero strobe: no change, no error.
- W1C hardware set: every cycle, reg |= i_reg_input slice. A set and a clear of the same bit in the same cycle leaves the bit 1 (set wins).
- Reads:
  - RW/W1C: return the register value.
  - RO: return the i_reg_input slice sampled at the completion edge.
  - Reads have no side effects.
- o_prdata and o_pslverr are 0 whenever o_pready=0.
- o_irq is combinational from register flops; no input-to-output combinational path.

Optional Feature:
- RGEN_APB_PROT_CHECK_EN defined:
  - An access with i_pprot[0]=0 (unprivileged) completes with normal latency.
  - Response: o_pslverr=1, o_prdata=0, no register change.
- Undefined: i_pprot is ignored.

Test Plan:
- Reset, defaults, INITIAL_VALUE reg0=32'hA5A5_0000: after reset, read 0x00 -> o_prdata=32'hA5A5_0000, o_pslverr=0, o_pready in first access cycle.
- WAIT_CYCLES=3, write 32'h1234_5678 with pstrb=4'b0101 to RW reg1 (was 0) -> o_pready in access cycle 4; o_reg_value slice1=32'h0034_0078.
- W1C reg2, pulse i_reg_input slice2=32'h0000_0011 -> o_irq=1.
  - Write 32'h0000_0001 -> reg2=32'h0000_0010, o_irq stays 1.
  - Write 32'h10 in the same cycle as a bit-4 set pulse -> bit 4 remains 1.
- RO reg3 with i_reg_input=32'hDEAD_BEEF:
  - Read -> 32'hDEAD_BEEF, no error.
  - Write -> o_pslverr=1, readback still 32'hDEAD_BEEF.
- NUM_REGS=8, read address 0x20 -> o_pslverr=1, o_prdata=0. Then deassert i_psel during WAIT -> no o_pready, no write committed.
- RGEN_APB_PROT_CHECK_EN defined, write with i_pprot=3'b000 -> o_pslverr=1, register unchanged. Same write with i_pprot=3'b001 succeeds.
